// File: rtl/bmp_stage_seq_pkg.sv
// Shared definitions for the bitmap stage sequencer: state encoding, widths
// and memory geometry used by the engines.
package bmp_stage_seq_pkg;

    localparam int ADDR_WIDTH      = 20;
    localparam int BYTE_WIDTH      = 8;
    localparam logic [ADDR_WIDTH-1:0] INIT_ADDR = '0;

    localparam int SEQ_STAGE_IDX_W = 3;
    localparam int SEQ_MAX_STAGES  = 8;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LAUNCH = 3'd1,
        SEQ_RUN    = 3'd2,
        SEQ_DRAIN  = 3'd3,
        SEQ_FINISH = 3'd4,
        SEQ_ERR    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/bmp_stage_seq_mem_mux.sv
// Combinational router for the shared memory port: forwards the selected
// engine's request when route_en is high, otherwise drives an idle port.
module seq_mem_mux #(
    parameter int NUM_STAGES = 2,
    parameter int ADDR_WIDTH = bmp_stage_seq_pkg::ADDR_WIDTH,
    parameter int BYTE_WIDTH = bmp_stage_seq_pkg::BYTE_WIDTH
) (
    input  logic [bmp_stage_seq_pkg::SEQ_STAGE_IDX_W-1:0] cur_stage,
    input  logic                                          route_en,
    input  logic [NUM_STAGES-1:0]                         stg_ren,
    input  logic [NUM_STAGES-1:0]                         stg_wen,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0]              stg_addr,
    input  logic [NUM_STAGES*BYTE_WIDTH-1:0]              stg_wdata,
    output logic                                          mem_ren,
    output logic                                          mem_wen,
    output logic [ADDR_WIDTH-1:0]                         mem_addr,
    output logic [BYTE_WIDTH-1:0]                         mem_wdata
);
    import bmp_stage_seq_pkg::*;

    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (route_en && (cur_stage == SEQ_STAGE_IDX_W'(k))) begin
                mem_ren   = stg_ren[k];
                mem_wen   = stg_wen[k];
                mem_addr  = stg_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata = stg_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/bmp_stage_seq.sv
// Sequencer that launches the enabled image engines in order, owns the shared
// memory port and watches for hung engines. SEQ_PERF_CNT_EN adds perf_cycles.
module bmp_stage_seq #(
    parameter int NUM_STAGES     = 2,
    parameter int ADDR_WIDTH     = bmp_stage_seq_pkg::ADDR_WIDTH,
    parameter int BYTE_WIDTH     = bmp_stage_seq_pkg::BYTE_WIDTH,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [NUM_STAGES-1:0]                         stage_mask,
    output logic [NUM_STAGES-1:0]                         stg_start,
    input  logic [NUM_STAGES-1:0]                         stg_done,
    input  logic [NUM_STAGES-1:0]                         stg_ren,
    input  logic [NUM_STAGES-1:0]                         stg_wen,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0]              stg_addr,
    input  logic [NUM_STAGES*BYTE_WIDTH-1:0]              stg_wdata,
    output logic [BYTE_WIDTH-1:0]                         stg_rdata,
    output logic                                          mem_ren,
    output logic                                          mem_wen,
    output logic [ADDR_WIDTH-1:0]                         mem_addr,
    output logic [BYTE_WIDTH-1:0]                         mem_wdata,
    input  logic [BYTE_WIDTH-1:0]                         mem_rdata,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          error,
    output logic [bmp_stage_seq_pkg::SEQ_STAGE_IDX_W-1:0] cur_stage
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                                   perf_cycles
`endif
);
    import bmp_stage_seq_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    seq_state_t                  state;
    logic [NUM_STAGES-1:0]       mask_q;
    logic [WD_W-1:0]             wdog;
    logic                        done_prev;
    logic [SEQ_MAX_STAGES-1:0]   done_ext;
    logic                        cur_done;
    logic                        rise;
    logic                        first_vld;
    logic                        next_vld;
    logic [SEQ_STAGE_IDX_W-1:0]  first_idx;
    logic [SEQ_STAGE_IDX_W-1:0]  next_idx;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [SEQ_STAGE_IDX_W-1:0] idx);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            oh[k] = (idx == SEQ_STAGE_IDX_W'(k));
        end
        return oh;
    endfunction

    // Widen the done bus so a 3-bit stage index can always address it.
    always_comb begin
        done_ext = '0;
        done_ext[NUM_STAGES-1:0] = stg_done;
    end

    assign cur_done = done_ext[cur_stage];
    assign rise     = cur_done & ~done_prev;

    // Descending scan leaves the lowest qualifying bit in each result.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stage_mask[k]) begin
                first_vld = 1'b1;
                first_idx = SEQ_STAGE_IDX_W'(k);
            end
            if (mask_q[k] && (SEQ_STAGE_IDX_W'(k) > cur_stage)) begin
                next_vld = 1'b1;
                next_idx = SEQ_STAGE_IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_IDLE;
            mask_q    <= '0;
            wdog      <= '0;
            done_prev <= 1'b0;
            cur_stage <= '0;
            stg_start <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            stg_start <= '0;
            done      <= 1'b0;
            if (abort) begin
                state     <= SEQ_IDLE;
                busy      <= 1'b0;
                cur_stage <= '0;
                wdog      <= '0;
            end else begin
                case (state)
                    SEQ_IDLE, SEQ_ERR: begin
                        if (start) begin
                            mask_q <= stage_mask;
                            error  <= 1'b0;
                            wdog   <= '0;
                            busy   <= 1'b1;
                            if (first_vld) begin
                                state     <= SEQ_LAUNCH;
                                cur_stage <= first_idx;
                                stg_start <= stage_onehot(first_idx);
                            end else begin
                                state     <= SEQ_FINISH;
                                cur_stage <= '0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    SEQ_LAUNCH: begin
                        // A done level already high here must fall before it counts.
                        done_prev <= cur_done;
                        state     <= SEQ_RUN;
                    end
                    SEQ_RUN: begin
                        done_prev <= cur_done;
                        wdog      <= wdog + 1'b1;
                        if (rise) begin
                            state <= SEQ_DRAIN;
                        end else if (wdog == WD_LAST) begin
                            state     <= SEQ_ERR;
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            cur_stage <= '0;
                            wdog      <= '0;
                        end
                    end
                    SEQ_DRAIN: begin
                        wdog <= '0;
                        if (next_vld) begin
                            state     <= SEQ_LAUNCH;
                            cur_stage <= next_idx;
                            stg_start <= stage_onehot(next_idx);
                        end else begin
                            state     <= SEQ_FINISH;
                            cur_stage <= '0;
                            done      <= 1'b1;
                        end
                    end
                    SEQ_FINISH: begin
                        state <= SEQ_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= SEQ_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    seq_mem_mux #(
        .NUM_STAGES (NUM_STAGES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_mem_mux (
        .cur_stage (cur_stage),
        .route_en  (state == SEQ_RUN),
        .stg_ren   (stg_ren),
        .stg_wen   (stg_wen),
        .stg_addr  (stg_addr),
        .stg_wdata (stg_wdata),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    assign stg_rdata = mem_rdata;

`ifdef SEQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (!abort && start && ((state == SEQ_IDLE) || (state == SEQ_ERR))) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= sat_inc32(perf_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_bmp_stage_seq.sv
// Directed bench for bmp_stage_seq: a main instance plus a short-watchdog
// instance (TIMEOUT_CYCLES=16) sharing the same stimulus.
module tb_bmp_stage_seq;
    localparam int NS = 2;
    localparam int AW = 20;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort;
    logic [NS-1:0]   stage_mask;
    logic [NS-1:0]   stg_done, stg_ren, stg_wen;
    logic [NS*AW-1:0] stg_addr;
    logic [NS*BW-1:0] stg_wdata;
    logic [BW-1:0]   mem_rdata;

    logic [NS-1:0]   stg_start, stg_start_w;
    logic [BW-1:0]   stg_rdata, stg_rdata_w;
    logic            mem_ren, mem_wen, mem_ren_w, mem_wen_w;
    logic [AW-1:0]   mem_addr, mem_addr_w;
    logic [BW-1:0]   mem_wdata, mem_wdata_w;
    logic            busy, done, error, busy_w, done_w, error_w;
    logic [2:0]      cur_stage, cur_stage_w;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]     perf_cycles, perf_cycles_w;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bmp_stage_seq #(.NUM_STAGES(NS), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stage_mask(stage_mask),
        .stg_start(stg_start), .stg_done(stg_done), .stg_ren(stg_ren), .stg_wen(stg_wen),
        .stg_addr(stg_addr), .stg_wdata(stg_wdata), .stg_rdata(stg_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .error(error), .cur_stage(cur_stage)
`ifdef SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    bmp_stage_seq #(.NUM_STAGES(NS), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .TIMEOUT_CYCLES(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stage_mask(stage_mask),
        .stg_start(stg_start_w), .stg_done(stg_done), .stg_ren(stg_ren), .stg_wen(stg_wen),
        .stg_addr(stg_addr), .stg_wdata(stg_wdata), .stg_rdata(stg_rdata_w),
        .mem_ren(mem_ren_w), .mem_wen(mem_wen_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
        .mem_rdata(mem_rdata), .busy(busy_w), .done(done_w), .error(error_w), .cur_stage(cur_stage_w)
`ifdef SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles_w)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; abort = 0; stage_mask = '0; stg_done = '0; stg_ren = '0; stg_wen = '0;
        stg_addr = '0; stg_wdata = '0; mem_rdata = '0;
    endtask

    task automatic sync_idle();
        clear_inputs();
        abort = 1; step(); abort = 0; step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1; #3; rst_n = 0;
        step(); step();
        total++; if ({stg_start, busy, done, error, cur_stage} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {stg_start, busy, done, error, cur_stage});
        end
        total++; if ({mem_ren, mem_wen, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL reset_mem got=%h exp=0", {mem_ren, mem_wen, mem_addr, mem_wdata});
        end
        rst_n = 1; step();
    endtask

    task automatic test_two_stages();
        bit bad_flag = 0;
        sync_idle();
        stage_mask = 2'b11; stg_ren = 2'b01; stg_addr[0 +: AW] = 20'h00200;
        start = 1; step(); start = 0;
        total++; if (stg_start !== 2'b01 || cur_stage !== 3'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL two_launch0 stg_start=%b cur=%0d busy=%b exp 01/0/1", stg_start, cur_stage, busy);
        end
        for (int c = 2; c <= 100; c++) begin
            step();
            if (c == 2) begin
                total++; if (mem_ren !== 1'b1 || mem_addr !== 20'h00200) begin
                    bad++; $display("FAIL two_route0 ren=%b addr=%h exp 1/00200", mem_ren, mem_addr);
                end
            end
            if (done !== 1'b0 || stg_start !== 2'b00) bad_flag = 1;
        end
        total++; if (bad_flag) begin bad++; $display("FAIL two_run0_quiet got=1 exp=0"); end
        stg_done[0] = 1;
        step();
        total++; if (mem_ren !== 1'b0 || stg_start !== 2'b00) begin
            bad++; $display("FAIL two_drain ren=%b stg_start=%b exp 0/00", mem_ren, stg_start);
        end
        step();
        total++; if (stg_start !== 2'b10 || cur_stage !== 3'd1) begin
            bad++; $display("FAIL two_launch1 stg_start=%b cur=%0d exp 10/1", stg_start, cur_stage);
        end
        stg_ren = 2'b00; stg_wen = 2'b10; stg_addr[AW +: AW] = 20'h00100; stg_wdata[BW +: BW] = 8'h5A;
        mem_rdata = 8'hC3;
        step();
        total++; if (mem_wen !== 1'b1 || mem_addr !== 20'h00100 || mem_wdata !== 8'h5A) begin
            bad++; $display("FAIL two_route1 wen=%b addr=%h wdata=%h exp 1/00100/5a", mem_wen, mem_addr, mem_wdata);
        end
        total++; if (stg_rdata !== 8'hC3) begin
            bad++; $display("FAIL two_rdata got=%h exp=c3", stg_rdata);
        end
        for (int c = 0; c < 49; c++) step();
        stg_done[1] = 1;
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL two_drain1_done got=%b exp=0", done); end
        step();
        total++; if (done !== 1'b1 || cur_stage !== 3'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL two_finish done=%b cur=%0d busy=%b exp 1/0/1", done, cur_stage, busy);
        end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            bad++; $display("FAIL two_idle done=%b busy=%b err=%b exp 0/0/0", done, busy, error);
        end
    endtask

    task automatic test_mask_skip();
        bit s0_seen = 0;
        bit leak = 0;
        sync_idle();
        stage_mask = 2'b10; stg_ren = 2'b01; stg_addr[0 +: AW] = 20'h00036;
        start = 1; step(); start = 0;
        total++; if (stg_start !== 2'b10 || cur_stage !== 3'd1) begin
            bad++; $display("FAIL skip_launch stg_start=%b cur=%0d exp 10/1", stg_start, cur_stage);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            if (stg_start[0] !== 1'b0) s0_seen = 1;
            if (mem_ren !== 1'b0 || mem_addr !== 20'h0) leak = 1;
            if (c == 6) stg_done[1] = 1;
        end
        total++; if (s0_seen) begin bad++; $display("FAIL skip_no_start0 got=1 exp=0"); end
        total++; if (leak) begin bad++; $display("FAIL skip_no_leak got=1 exp=0"); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL skip_completed busy=%b exp=0", busy); end
    endtask

    task automatic test_done_high_at_launch();
        bit early = 0;
        sync_idle();
        stage_mask = 2'b01; stg_done = 2'b01;
        start = 1; step(); start = 0;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b1) early = 1;
            if (c == 20) stg_done[0] = 0;
            if (c == 40) stg_done[0] = 1;
        end
        total++; if (early) begin bad++; $display("FAIL prehigh_early got=1 exp=0"); end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL prehigh_drain done=%b busy=%b exp 0/1", done, busy);
        end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL prehigh_finish done=%b exp=1", done); end
    endtask

    task automatic test_timeout();
        bit early = 0;
        sync_idle();
        stage_mask = 2'b01; stg_ren = 2'b01; stg_wen = 2'b01; stg_addr[0 +: AW] = 20'h00044;
        start = 1; step(); start = 0;
        total++; if (stg_start_w !== 2'b01) begin bad++; $display("FAIL wd_launch got=%b exp=01", stg_start_w); end
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) begin
                total++; if (mem_ren_w !== 1'b1 || mem_addr_w !== 20'h00044) begin
                    bad++; $display("FAIL wd_route ren=%b addr=%h exp 1/00044", mem_ren_w, mem_addr_w);
                end
            end
            if (busy_w !== 1'b1 || error_w !== 1'b0) early = 1;
        end
        total++; if (early) begin bad++; $display("FAIL wd_early_err got=1 exp=0"); end
        step();
        total++; if (error_w !== 1'b1 || busy_w !== 1'b0 || mem_ren_w !== 1'b0 || mem_wen_w !== 1'b0 || mem_addr_w !== 20'h0) begin
            bad++; $display("FAIL wd_err err=%b busy=%b ren=%b wen=%b addr=%h exp 1/0/0/0/0",
                            error_w, busy_w, mem_ren_w, mem_wen_w, mem_addr_w);
        end
        start = 1; step(); start = 0;
        total++; if (error_w !== 1'b0 || stg_start_w !== 2'b01 || busy_w !== 1'b1) begin
            bad++; $display("FAIL wd_restart err=%b stg_start=%b busy=%b exp 0/01/1", error_w, stg_start_w, busy_w);
        end
        for (int i = 0; i < 17; i++) step();
        abort = 1; step(); abort = 0;
        total++; if (error_w !== 1'b1 || busy_w !== 1'b0) begin
            bad++; $display("FAIL wd_abort_sticky err=%b busy=%b exp 1/0", error_w, busy_w);
        end
    endtask

    task automatic test_abort();
        bit spurious = 0;
        sync_idle();
        stage_mask = 2'b11;
        start = 1; step(); start = 0;
        step();
        stg_done[0] = 1;
        step(); step();
        stg_wen = 2'b10; stg_addr[AW +: AW] = 20'h00100; stg_wdata[BW +: BW] = 8'h77;
        step();
        total++; if (mem_wen !== 1'b1 || mem_addr !== 20'h00100 || cur_stage !== 3'd1) begin
            bad++; $display("FAIL abort_pre wen=%b addr=%h cur=%0d exp 1/00100/1", mem_wen, mem_addr, cur_stage);
        end
        abort = 1; step(); abort = 0;
        total++; if (busy !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 20'h0 || cur_stage !== 3'd0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_idle busy=%b wen=%b addr=%h cur=%0d done=%b exp 0/0/0/0/0",
                            busy, mem_wen, mem_addr, cur_stage, done);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done !== 1'b0 || stg_start !== 2'b00 || busy !== 1'b0) spurious = 1;
        end
        total++; if (spurious) begin bad++; $display("FAIL abort_quiet got=1 exp=0"); end
        abort = 1; start = 1; step(); abort = 0; start = 0;
        total++; if (busy !== 1'b0 || stg_start !== 2'b00) begin
            bad++; $display("FAIL abort_vs_start busy=%b stg_start=%b exp 0/00", busy, stg_start);
        end
        step();
        total++; if (busy !== 1'b0 || stg_start !== 2'b00 || done !== 1'b0) begin
            bad++; $display("FAIL abort_vs_start_after busy=%b stg_start=%b done=%b exp 0/00/0", busy, stg_start, done);
        end
    endtask

    task automatic test_empty_mask();
        sync_idle();
        stage_mask = 2'b00;
        start = 1; step(); start = 0;
        total++; if (done !== 1'b1 || stg_start !== 2'b00 || busy !== 1'b1) begin
            bad++; $display("FAIL empty_finish done=%b stg_start=%b busy=%b exp 1/00/1", done, stg_start, busy);
        end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0 || stg_start !== 2'b00) begin
            bad++; $display("FAIL empty_idle done=%b busy=%b stg_start=%b exp 0/0/00", done, busy, stg_start);
        end
`ifdef SEQ_PERF_CNT_EN
        step();
        total++; if (perf_cycles !== 32'd1) begin
            bad++; $display("FAIL empty_perf got=%0d exp=1", perf_cycles);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        sync_idle();
        stage_mask = 2'b11; stg_ren = 2'b01;
        start = 1; step(); start = 0;
        step(); step();
        total++; if (mem_ren !== 1'b1) begin bad++; $display("FAIL midrst_pre ren=%b exp=1", mem_ren); end
        rst_n = 0; #1;
        total++; if (busy !== 1'b0 || mem_ren !== 1'b0 || cur_stage !== 3'd0 || stg_start !== 2'b00) begin
            bad++; $display("FAIL midrst_async busy=%b ren=%b cur=%0d stg_start=%b exp 0/0/0/00",
                            busy, mem_ren, cur_stage, stg_start);
        end
        step(); rst_n = 1; step();
        total++; if (busy !== 1'b0 || mem_ren !== 1'b0) begin
            bad++; $display("FAIL midrst_after busy=%b ren=%b exp 0/0", busy, mem_ren);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout elapsed=%0t limit=100000", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_two_stages();
        test_mask_skip();
        test_done_high_at_launch();
        test_timeout();
        test_abort();
        test_empty_mask();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
